// File: rtl/hold_stable_pkg.sv
// Shared types and default sizing for the hold-stable valid/ready transmitter.
package hold_stable_pkg;

  typedef enum logic {IDLE, PRESENT} tx_state_e;

  localparam int unsigned DEF_WIDTH   = 8;
  localparam int unsigned DEF_DEPTH   = 4;
  localparam int unsigned DEF_STALL_W = 8;

endpackage

// File: rtl/hold_stable_fifo.sv
// Producer-side FIFO: storage, wrapping pointers, occupancy level and registered full flag.
module hold_stable_fifo
  import hold_stable_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    level_next;
  logic             push;

  // Gated on the registered full only, so a same-cycle pop never admits a write.
  assign push    = wr_en && !full;
  assign rd_data = mem[rd_ptr];

  always_comb begin
    level_next = level;
    if (push && !pop)
      level_next = level + LW'(1);
    else if (!push && pop)
      level_next = level - LW'(1);
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      level <= level_next;
      full  <= (level_next == DEPTH_L);
    end
  end

endmodule

// File: rtl/hold_stable_tx.sv
// Valid/ready transmitter holding out_valid/out_data stable until accepted.
// Define HOLD_STABLE_ASSERT_EN to compile the embedded interface assertions.
module hold_stable_tx
  import hold_stable_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned DEPTH   = DEF_DEPTH,
  parameter int unsigned STALL_W = DEF_STALL_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  output logic                     full,
  output logic                     overflow,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic [STALL_W-1:0]       stall_cnt
);

  tx_state_e        state;
  logic [WIDTH-1:0] head;
  logic             pop;

  // Pop whenever the output register is empty or being emptied this edge.
  assign pop = ((state == IDLE) || out_ready) && (level != '0);

  hold_stable_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .pop     (pop),
    .rd_data (head),
    .level   (level),
    .full    (full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_data  <= '0;
      stall_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          stall_cnt <= '0;
          if (pop) begin
            out_data  <= head;
            out_valid <= 1'b1;
            state     <= PRESENT;
          end
        end
        PRESENT: begin
          if (out_ready) begin
            stall_cnt <= '0;
            if (pop) begin
              out_data <= head;
            end else begin
              out_valid <= 1'b0;
              state     <= IDLE;
            end
          end else if (stall_cnt != '1) begin
            stall_cnt <= stall_cnt + STALL_W'(1);
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      overflow <= 1'b0;
    else if (wr_en && full)
      overflow <= 1'b1;
  end

`ifdef HOLD_STABLE_ASSERT_EN
  a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
      out_valid && !out_ready |=> out_valid && $stable(out_data))
    $info("%0t a_hold_stable pass", $time);
  else
    $error("%0t a_hold_stable fail", $time);

  a_full_level: assert property (@(posedge clk) disable iff (!rst_n)
      full |-> level == ($clog2(DEPTH)+1)'(DEPTH))
    $info("%0t a_full_level pass", $time);
  else
    $error("%0t a_full_level fail", $time);

  a_valid_known: assert property (@(posedge clk) disable iff (!rst_n)
      !(out_valid === 1'bx))
    $info("%0t a_valid_known pass", $time);
  else
    $error("%0t a_valid_known fail", $time);
`else
`endif

endmodule

// File: tb/tb_hold_stable_tx.sv
// Randomized self-checking bench for hold_stable_tx against a queue-based reference model.
module tb_hold_stable_tx;

  localparam int unsigned WIDTH   = 8;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned STALL_W = 8;
  localparam int unsigned STALL_MAX = (1 << STALL_W) - 1;

  logic             clk;
  logic             rst_n;
  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             full;
  logic             overflow;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic [2:0]       level;
  logic [STALL_W-1:0] stall_cnt;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model state
  logic [WIDTH-1:0] m_q[$];
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  int unsigned      m_stall;
  logic             m_ovf;

  hold_stable_tx #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .STALL_W (STALL_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .full      (full),
    .overflow  (overflow),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .level     (level),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_valid = 1'b0;
    m_data  = '0;
    m_stall = 0;
    m_ovf   = 1'b0;
  endtask

  // One clock edge of the transmitter rules, in terms of words held and words offered.
  task automatic model_edge(input logic w, input logic [WIDTH-1:0] d, input logic r);
    bit was_full;
    was_full = (m_q.size() == DEPTH);
    if (w && was_full)
      m_ovf = 1'b1;
    if (m_valid && !r)
      m_stall = (m_stall == STALL_MAX) ? STALL_MAX : m_stall + 1;
    else
      m_stall = 0;
    if (!m_valid || r) begin
      if (m_q.size() != 0) begin
        m_data  = m_q.pop_front();
        m_valid = 1'b1;
      end else begin
        m_valid = 1'b0;
      end
    end
    if (w && !was_full)
      m_q.push_back(d);
  endtask

  task automatic compare_all();
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("out_data",  32'(out_data),  32'(m_data));
    check("level",     32'(level),     32'(m_q.size()));
    check("full",      32'(full),      32'(m_q.size() == DEPTH));
    check("overflow",  32'(overflow),  32'(m_ovf));
    check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
  endtask

  task automatic tick(input logic w, input logic [WIDTH-1:0] d, input logic r);
    wr_en     = w;
    wr_data   = d;
    out_ready = r;
    @(posedge clk);
    model_edge(w, d, r);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    wr_en     = 1'b0;
    wr_data   = '0;
    out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    #2 rst_n = 1'b1;
  endtask

  initial begin
    int unsigned k;
    logic [WIDTH-1:0] d;
    rst_n = 1'b1;
    #1;
    do_reset();

    // Single word latency with sink ready
    tick(1'b1, 8'hA5, 1'b1);
    check("t1_valid_n", 32'(out_valid), 32'd0);
    tick(1'b0, 8'h00, 1'b1);
    check("t1_valid_n1", 32'(out_valid), 32'd1);
    check("t1_data_n1", 32'(out_data), 32'hA5);
    tick(1'b0, 8'h00, 1'b1);
    check("t1_valid_n2", 32'(out_valid), 32'd0);
    check("t1_data_held", 32'(out_data), 32'hA5);

    // Hold while stalled, then back-to-back drain
    tick(1'b1, 8'h11, 1'b0);
    tick(1'b1, 8'h22, 1'b0);
    tick(1'b1, 8'h33, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 8'h00, 1'b0);
      check("t2_hold", 32'(out_data), 32'h11);
    end
    check("t2_stall", 32'(stall_cnt), 32'd6);
    tick(1'b0, 8'h00, 1'b1);
    check("t2_b2b_22", 32'(out_data), 32'h22);
    check("t2_stall_clr", 32'(stall_cnt), 32'd0);
    tick(1'b0, 8'h00, 1'b1);
    check("t2_b2b_33", 32'(out_data), 32'h33);
    tick(1'b0, 8'h00, 1'b1);
    check("t2_idle", 32'(out_valid), 32'd0);

    // Overfill: one in output register, DEPTH queued, sixth dropped
    for (int i = 0; i < 6; i++)
      tick(1'b1, 8'(8'hC0 + i), 1'b0);
    check("t3_level", 32'(level), 32'(DEPTH));
    check("t3_full", 32'(full), 32'd1);
    check("t3_ovf", 32'(overflow), 32'd1);
    k = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) begin
        check("t3_order", 32'(out_data), 32'(8'hC0 + k));
        k++;
      end
      tick(1'b0, 8'h00, 1'b1);
    end
    check("t3_count", k, 32'd5);
    check("t3_ovf_sticky", 32'(overflow), 32'd1);

    // Asynchronous reset in PRESENT with overflow set
    for (int i = 0; i < 6; i++)
      tick(1'b1, 8'(8'h50 + i), 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("t5_valid", 32'(out_valid), 32'd0);
    check("t5_level", 32'(level), 32'd0);
    check("t5_ovf", 32'(overflow), 32'd0);
    check("t5_full", 32'(full), 32'd0);
    check("t5_stall", 32'(stall_cnt), 32'd0);
    do_reset();

    // Alternating ready under continuous writes
    for (int i = 0; i < 20; i++) begin
      tick(1'b1, 8'(8'h80 + i), 1'(i % 2));
      check("t4_level_bound", 32'(level <= 3'(DEPTH)), 32'd1);
    end
    for (int i = 0; i < 12; i++)
      tick(1'b0, 8'h00, 1'b1);
    check("t4_drained", 32'(out_valid), 32'd0);

    // Stall counter saturation
    tick(1'b1, 8'h77, 1'b0);
    for (int i = 0; i < 300; i++)
      tick(1'b0, 8'h00, 1'b0);
    check("t6_sat", 32'(stall_cnt), 32'(STALL_MAX));
    check("t6_hold", 32'(out_data), 32'h77);
    tick(1'b0, 8'h00, 1'b1);
    check("t6_clr", 32'(stall_cnt), 32'd0);

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      d = 8'($urandom);
      tick(1'($urandom_range(0, 3) != 0), d, 1'($urandom_range(0, 2) != 0));
    end
    for (int i = 0; i < 10; i++)
      tick(1'b0, 8'h00, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
